// File: rtl/mmu_bridge_pkg.sv
// Shared definitions for the MMU merge-to-pipeline bridge: FSM encoding,
// pointer sizing and parameter legality.
package mmu_bridge_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // One extra MSB over the index bits distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit params_legal(input int depth, input int sync_stages);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) && (sync_stages >= 2);
  endfunction

endpackage

// File: rtl/mmu_sync_chain.sv
// N-flop single-bit synchronizer with asynchronous active-low reset.
module mmu_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/mmu_merge_sync_bridge.sv
// Captures requests on the upstream drive edge, moves them into the clk
// domain via a toggle synchronizer and queues them in a small FIFO.
module mmu_merge_sync_bridge
  import mmu_bridge_pkg::*;
#(
  parameter int DATA_WIDTH  = 88,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_drive,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic                    o_free,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data,
  input  logic                    i_ready,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  if (!params_legal(DEPTH, SYNC_STAGES)) begin : g_param_check
    $error("mmu_merge_sync_bridge: DEPTH must be a power of two >= 2, SYNC_STAGES >= 2");
  end

  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  req_tgl_reg;
  logic                  req_tgl_sync;
  logic                  tgl_last_reg;
  logic                  new_req_reg;
  logic                  free_reg;
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [PW-1:0]         count_reg;
  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  state_e                state_reg;
  state_e                state_next;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // hold_reg stays stable until o_free, so the clk domain may sample it freely.
  always_ff @(posedge i_drive or negedge rstn) begin
    if (!rstn) begin
      hold_reg    <= '0;
      req_tgl_reg <= 1'b0;
    end else begin
      hold_reg    <= i_data;
      req_tgl_reg <= ~req_tgl_reg;
    end
  end

  mmu_sync_chain #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (req_tgl_reg),
    .q    (req_tgl_sync)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tgl_last_reg <= 1'b0;
      new_req_reg  <= 1'b0;
    end else begin
      tgl_last_reg <= req_tgl_sync;
      new_req_reg  <= req_tgl_sync ^ tgl_last_reg;
    end
  end

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop   = !empty && i_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (new_req_reg && full) state_next = ST_WAIT;
      ST_WAIT: if (!full)               state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Fullness is the start-of-cycle value, so a pop never frees a slot early.
  always_comb begin
    push = 1'b0;
    case (state_reg)
      ST_IDLE: push = new_req_reg && !full;
      ST_WAIT: push = !full;
      default: push = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      free_reg   <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      free_reg <= push;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + PW'(1);
        2'b01:   count_reg <= count_reg - PW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        mem_reg[gi] <= '0;
      end else if (push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
        mem_reg[gi] <= hold_reg;
      end
    end
  end

  assign o_free  = free_reg;
  assign o_valid = (count_reg != '0);
  assign o_data  = mem_reg[rd_ptr_reg[AW-1:0]];
  assign o_count = count_reg;

endmodule

// File: tb/tb_mmu_merge_sync_bridge.sv
// Directed bench for mmu_merge_sync_bridge with a queue-level reference model.
module tb_mmu_merge_sync_bridge;

  localparam int DW    = 88;
  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_drive;
  logic [DW-1:0] i_data;
  logic          o_free;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          i_ready;
  logic [$clog2(DEPTH):0] o_count;

  mmu_merge_sync_bridge #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_drive (i_drive),
    .i_data  (i_data),
    .o_free  (o_free),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  // Requests issued by the stimulus: payload and the edge at which they become eligible.
  logic [DW-1:0] req_data [64];
  int            req_due  [64];
  int            req_total = 0;

  // Reference model: accepted-but-unread requests in order.
  logic [DW-1:0] exp_q [$];
  bit            exp_free = 1'b0;
  int            edge_cnt = 0;
  int            acc_idx  = 0;
  int            m_sz;
  bit            m_pop;
  bit            m_acc;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q.delete();
      exp_free = 1'b0;
      acc_idx  = req_total;
    end else begin
      edge_cnt = edge_cnt + 1;
      m_sz  = exp_q.size();
      m_pop = (m_sz > 0) && i_ready;
      m_acc = (acc_idx < req_total) && (edge_cnt >= req_due[acc_idx]) && (m_sz < DEPTH);
      if (m_pop) void'(exp_q.pop_front());
      if (m_acc) begin
        exp_q.push_back(req_data[acc_idx]);
        acc_idx = acc_idx + 1;
      end
      exp_free = m_acc;
    end
  end

  int            n_vec = 0;
  int            n_err = 0;
  int            free_cnt = 0;
  int            max_cnt = 0;
  logic [DW-1:0] popped [$];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    if (rstn && o_valid && i_ready) popped.push_back(o_data);
    @(negedge clk);
    if (o_free) free_cnt++;
    if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
    chk("count", 96'(o_count), 96'(exp_q.size()));
    chk("valid", 96'(o_valid), 96'(exp_q.size() != 0));
    chk("free",  96'(o_free),  96'(exp_free));
    if (exp_q.size() != 0) chk("data", 96'(o_data), 96'(exp_q[0]));
  endtask

  task automatic drive_req(input logic [DW-1:0] d);
    i_data             = d;
    req_data[req_total] = d;
    req_due[req_total]  = edge_cnt + SS + 2;
    req_total++;
    i_drive = 1'b1;
    tick();
    i_drive = 1'b0;
  endtask

  task automatic wait_free(input int max, input bit rnd, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < max) begin
      if (rnd) i_ready = 1'($urandom_range(0, 1));
      tick();
      lat++;
      seen = o_free;
    end
    chk("free_timeout", 96'(seen), 96'(1));
  endtask

  int            lat;
  int            base;
  logic [DW-1:0] want;

  initial begin
    rstn = 1'b1; i_drive = 1'b0; i_data = '0; i_ready = 1'b0;
    #1 rstn = 1'b0;
    repeat (3) tick();
    chk("rst_free",  96'(o_free),  96'(0));
    chk("rst_valid", 96'(o_valid), 96'(0));
    chk("rst_count", 96'(o_count), 96'(0));
    chk("rst_data",  96'(o_data),  96'(0));
    rstn = 1'b1;
    repeat (2) tick();

    // Single request with the sink ready.
    i_ready = 1'b1;
    drive_req(88'h1234);
    wait_free(20, 1'b0, lat);
    chk("single_latency_ok", 96'((lat + 1 >= SS + 2) && (lat + 1 <= SS + 3)), 96'(1));
    chk("single_valid", 96'(o_valid), 96'(1));
    chk("single_data",  96'(o_data),  96'(88'h1234));
    tick();
    chk("single_drained", 96'(o_valid), 96'(0));
    chk("single_popped",  96'(popped[0]), 96'(88'h1234));

    // Fill and stall: four accepted, fifth parked in WAIT.
    i_ready = 1'b0;
    popped.delete();
    base = free_cnt;
    for (int i = 1; i <= 4; i++) begin
      drive_req(DW'(i));
      wait_free(20, 1'b0, lat);
    end
    drive_req(DW'(5));
    repeat (10) tick();
    chk("fill_count", 96'(o_count), 96'(4));
    chk("fill_frees", 96'(free_cnt - base), 96'(4));

    // One-cycle pop at full: 4 -> 3, then 3 -> 4 with the fifth o_free.
    i_ready = 1'b1;
    tick();
    chk("popfull_count3", 96'(o_count), 96'(3));
    i_ready = 1'b0;
    tick();
    chk("popfull_count4", 96'(o_count), 96'(4));
    chk("popfull_free",   96'(o_free),  96'(1));
    i_ready = 1'b1;
    repeat (6) tick();
    chk("fill_pop_total", 96'(popped.size()), 96'(5));
    for (int i = 0; i < 5 && i < popped.size(); i++) begin
      want = DW'(i + 1);
      chk("fill_order", 96'(popped[i]), 96'(want));
    end

    // Pointer wrap with a random sink.
    popped.delete();
    base = free_cnt;
    max_cnt = 0;
    for (int i = 0; i < 3 * DEPTH + 1; i++) begin
      drive_req(DW'(88'h100 + i));
      wait_free(80, 1'b1, lat);
    end
    i_ready = 1'b1;
    repeat (8) tick();
    chk("wrap_frees",    96'(free_cnt - base), 96'(3 * DEPTH + 1));
    chk("wrap_pops",     96'(popped.size()),   96'(3 * DEPTH + 1));
    chk("wrap_max_ok",   96'(max_cnt <= DEPTH), 96'(1));
    for (int i = 0; i < popped.size(); i++) begin
      want = DW'(88'h100 + i);
      chk("wrap_order", 96'(popped[i]), 96'(want));
    end

    // Reset with two entries stored and a third in flight.
    i_ready = 1'b0;
    drive_req(88'hA1);
    wait_free(20, 1'b0, lat);
    drive_req(88'hA2);
    wait_free(20, 1'b0, lat);
    drive_req(88'hA3);
    tick();
    chk("pre_rst_count", 96'(o_count), 96'(2));
    rstn = 1'b0;
    #1;
    chk("midrst_free",  96'(o_free),  96'(0));
    chk("midrst_valid", 96'(o_valid), 96'(0));
    chk("midrst_count", 96'(o_count), 96'(0));
    chk("midrst_data",  96'(o_data),  96'(0));
    repeat (3) tick();
    rstn = 1'b1;
    base = free_cnt;
    repeat (10) tick();
    chk("postrst_no_free", 96'(free_cnt - base), 96'(0));
    drive_req(88'hABC);
    wait_free(20, 1'b0, lat);
    chk("postrst_count", 96'(o_count), 96'(1));
    chk("postrst_data",  96'(o_data),  96'(88'hABC));
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
